// File: rtl/uart_boot_loader_if.sv
// Instruction-memory write port driven by the UART boot loader.
// The loader owns the strobe, address and data; the memory only observes them.
interface uart_boot_loader_if;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;

    modport master (output imem_we, output imem_waddr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_waddr, input  imem_wdata);
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a little-endian word-count header followed by that many
// 32-bit words over 8N1 serial, writes them to IMEM, then enables the core.
module uart_boot_loader #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int MAX_WORDS = 2048
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                uart_rx,
    uart_boot_loader_if.master  imem,
    output logic                system_ena,
    output logic                load_error,
    output logic [15:0]         words_loaded
);
    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [15:0] BIT_M1       = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_M1      = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] MAX_W32      = 32'(MAX_WORDS);
    localparam logic [15:0] MAX_W16      = 16'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {HDR, LOAD, DONE, ERR} ld_state_t;

    // Two-flop synchronizer; resets to the idle-high line level.
    logic [1:0] sync_reg;
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (reset) sync_reg[gi] <= 1'b1;
                else       sync_reg[gi] <= (gi == 0) ? uart_rx : sync_reg[gi - ((gi == 0) ? 0 : 1)];
            end
        end
    endgenerate

    logic       rx_s;
    assign rx_s = sync_reg[1];

    rx_state_t   rx_state_reg;
    logic [15:0] clk_cnt_reg;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  rx_shift_reg;
    logic        rx_prev_reg;
    logic        rx_valid_reg;
    logic        frame_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_reg  <= RX_IDLE;
            clk_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            rx_shift_reg  <= '0;
            rx_prev_reg   <= 1'b1;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            rx_prev_reg   <= rx_s;
            case (rx_state_reg)
                RX_IDLE: begin
                    clk_cnt_reg <= '0;
                    if (rx_prev_reg && !rx_s) rx_state_reg <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt_reg == HALF_M1) begin
                        clk_cnt_reg  <= '0;
                        bit_cnt_reg  <= '0;
                        // A line already back high at mid-start was a glitch.
                        rx_state_reg <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_reg == BIT_M1) begin
                        clk_cnt_reg  <= '0;
                        rx_shift_reg <= {rx_s, rx_shift_reg[7:1]};
                        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) rx_state_reg <= RX_STOP;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_reg == BIT_M1) begin
                        clk_cnt_reg   <= '0;
                        rx_state_reg  <= RX_IDLE;
                        rx_valid_reg  <= rx_s;
                        frame_err_reg <= !rx_s;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 16'd1;
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    ld_state_t   ld_state_reg;
    logic [1:0]  byte_idx_reg;
    logic [31:0] asm_reg;
    logic [31:0] count_reg;
    logic [31:0] word_idx_reg;
    logic        we_reg;
    logic [31:0] waddr_reg;
    logic [31:0] wdata_reg;
    logic        ena_reg;
    logic        err_reg;
    logic [15:0] loaded_reg;
    logic [31:0] asm_next;

    // Bytes arrive LSB first, so each new byte enters at the top.
    assign asm_next = {rx_shift_reg, asm_reg[31:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state_reg <= HDR;
            byte_idx_reg <= '0;
            asm_reg      <= '0;
            count_reg    <= '0;
            word_idx_reg <= '0;
            we_reg       <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            ena_reg      <= 1'b0;
            err_reg      <= 1'b0;
            loaded_reg   <= '0;
        end else begin
            we_reg <= 1'b0;
            case (ld_state_reg)
                HDR: begin
                    if (frame_err_reg) begin
                        ld_state_reg <= ERR;
                        err_reg      <= 1'b1;
                    end else if (rx_valid_reg) begin
                        asm_reg      <= asm_next;
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            count_reg    <= asm_next;
                            word_idx_reg <= '0;
                            if (asm_next == 32'd0) begin
                                ld_state_reg <= DONE;
                                ena_reg      <= 1'b1;
                            end else if (asm_next > MAX_W32) begin
                                ld_state_reg <= ERR;
                                err_reg      <= 1'b1;
                            end else begin
                                ld_state_reg <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (frame_err_reg) begin
                        ld_state_reg <= ERR;
                        err_reg      <= 1'b1;
                    end else if (we_reg && word_idx_reg == count_reg) begin
                        // Enable follows the cycle that carried the last write strobe.
                        ld_state_reg <= DONE;
                        ena_reg      <= 1'b1;
                    end else if (rx_valid_reg) begin
                        asm_reg      <= asm_next;
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            we_reg       <= 1'b1;
                            waddr_reg    <= {word_idx_reg[29:0], 2'b00};
                            wdata_reg    <= asm_next;
                            word_idx_reg <= word_idx_reg + 32'd1;
                            if (loaded_reg < MAX_W16) loaded_reg <= loaded_reg + 16'd1;
                        end
                    end
                end
                DONE: ena_reg <= 1'b1;
                ERR: begin
                    err_reg <= 1'b1;
                    ena_reg <= 1'b0;
                end
                default: ld_state_reg <= HDR;
            endcase
        end
    end

    assign imem.imem_we    = we_reg;
    assign imem.imem_waddr = waddr_reg;
    assign imem.imem_wdata = wdata_reg;
    assign system_ena      = ena_reg;
    assign load_error      = err_reg;
    assign words_loaded    = loaded_reg;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: serializes boot images over uart_rx and compares the
// observed IMEM writes and status against the expected image contents.
module tb_uart_boot_loader;
    localparam int CLK_FREQ  = 1_600_000;
    localparam int BAUD      = 100_000;
    localparam int MAX_WORDS = 2048;
    localparam int CPB       = CLK_FREQ / BAUD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx = 1'b1;
    logic        system_ena;
    logic        load_error;
    logic [15:0] words_loaded;

    uart_boot_loader_if bus ();

    uart_boot_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .imem(bus.master),
        .system_ena(system_ena), .load_error(load_error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int          cyc = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          last_we_cyc = -1;
    int          ena_rise_cyc = -1;
    logic        ena_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wa_q.push_back(bus.imem_waddr);
            wd_q.push_back(bus.imem_wdata);
            last_we_cyc = cyc;
        end
        if (system_ena === 1'b1 && ena_prev !== 1'b1) ena_rise_cyc = cyc;
        ena_prev = system_ena;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        wa_q.delete();
        wd_q.delete();
        last_we_cyc = -1;
        ena_rise_cyc = -1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.imem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.imem_we); end
        checks++; if (bus.imem_waddr !== 32'd0) begin failures++; $display("FAIL reset_waddr got=%h exp=0", bus.imem_waddr); end
        checks++; if (bus.imem_wdata !== 32'd0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", bus.imem_wdata); end
        checks++; if (system_ena !== 1'b0) begin failures++; $display("FAIL reset_ena got=%b exp=0", system_ena); end
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", load_error); end
        checks++; if (words_loaded !== 16'd0) begin failures++; $display("FAIL reset_words got=%0d exp=0", words_loaded); end
        $display("test_reset done");
    endtask

    task automatic test_two_words();
        logic [31:0] img[2];
        img[0] = 32'h2008_0005;
        img[1] = 32'h3C01_ABCD;
        do_reset();
        send_word(32'd2);
        foreach (img[i]) send_word(img[i]);
        repeat (4 * CPB) @(negedge clk);
        checks++; if (wa_q.size() !== 2) begin failures++; $display("FAIL two_count got=%0d exp=2", wa_q.size()); end
        for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
            checks++; if (wa_q[i] !== 32'(i * 4)) begin failures++; $display("FAIL two_addr%0d got=%h exp=%h", i, wa_q[i], i * 4); end
            checks++; if (wd_q[i] !== img[i]) begin failures++; $display("FAIL two_data%0d got=%h exp=%h", i, wd_q[i], img[i]); end
        end
        checks++; if (words_loaded !== 16'd2) begin failures++; $display("FAIL two_words got=%0d exp=2", words_loaded); end
        checks++; if (system_ena !== 1'b1) begin failures++; $display("FAIL two_ena got=%b exp=1", system_ena); end
        checks++; if (ena_rise_cyc !== last_we_cyc + 1) begin failures++; $display("FAIL two_ena_time got=%0d exp=%0d", ena_rise_cyc, last_we_cyc + 1); end
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL two_err got=%b exp=0", load_error); end
        $display("test_two_words writes=%0d words_loaded=%0d ena=%b", wa_q.size(), words_loaded, system_ena);
    endtask

    task automatic test_zero_header();
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        checks++; if (system_ena !== 1'b0) begin failures++; $display("FAIL zero_ena_early got=%b exp=0", system_ena); end
        send_byte(8'h00, 1'b1);
        send_word($urandom);
        checks++; if (system_ena !== 1'b1) begin failures++; $display("FAIL zero_ena got=%b exp=1", system_ena); end
        checks++; if (wa_q.size() !== 0) begin failures++; $display("FAIL zero_writes got=%0d exp=0", wa_q.size()); end
        checks++; if (words_loaded !== 16'd0) begin failures++; $display("FAIL zero_words got=%0d exp=0", words_loaded); end
        $display("test_zero_header ena=%b writes=%0d", system_ena, wa_q.size());
    endtask

    task automatic test_oversize();
        do_reset();
        send_word(32'(MAX_WORDS + 1));
        send_word($urandom);
        send_word($urandom);
        checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL over_err got=%b exp=1", load_error); end
        checks++; if (system_ena !== 1'b0) begin failures++; $display("FAIL over_ena got=%b exp=0", system_ena); end
        checks++; if (wa_q.size() !== 0) begin failures++; $display("FAIL over_writes got=%0d exp=0", wa_q.size()); end
        $display("test_oversize err=%b writes=%0d", load_error, wa_q.size());
    endtask

    task automatic test_framing();
        do_reset();
        send_word(32'd1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (4 * CPB) @(negedge clk);
        checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL frame_err got=%b exp=1", load_error); end
        checks++; if (wa_q.size() !== 0) begin failures++; $display("FAIL frame_writes got=%0d exp=0", wa_q.size()); end
        checks++; if (system_ena !== 1'b0) begin failures++; $display("FAIL frame_ena got=%b exp=0", system_ena); end
        $display("test_framing err=%b writes=%0d", load_error, wa_q.size());
    endtask

    task automatic test_glitch();
        logic [31:0] w;
        w = $urandom;
        do_reset();
        uart_rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_word(32'd1);
        send_word(w);
        repeat (4 * CPB) @(negedge clk);
        checks++; if (wa_q.size() !== 1) begin failures++; $display("FAIL glitch_writes got=%0d exp=1", wa_q.size()); end
        if (wa_q.size() > 0) begin
            checks++; if (wd_q[0] !== w || wa_q[0] !== 32'd0) begin failures++; $display("FAIL glitch_data got=%h@%h exp=%h@0", wd_q[0], wa_q[0], w); end
        end
        checks++; if (system_ena !== 1'b1 || load_error !== 1'b0) begin failures++; $display("FAIL glitch_status got=ena%b err%b exp=ena1 err0", system_ena, load_error); end
        $display("test_glitch writes=%0d ena=%b", wa_q.size(), system_ena);
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] w0, w1;
        w0 = $urandom;
        w1 = $urandom;
        do_reset();
        send_word(32'd3);
        send_word(w0);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        checks++; if (wa_q.size() !== 1 || words_loaded !== 16'd1) begin failures++; $display("FAIL mid_partial got=%0d/%0d exp=1/1", wa_q.size(), words_loaded); end
        do_reset();
        checks++; if (bus.imem_we !== 1'b0 || bus.imem_waddr !== 32'd0 || bus.imem_wdata !== 32'd0)
            begin failures++; $display("FAIL mid_reset_bus got=%b %h %h exp=0 0 0", bus.imem_we, bus.imem_waddr, bus.imem_wdata); end
        checks++; if (system_ena !== 1'b0 || load_error !== 1'b0 || words_loaded !== 16'd0)
            begin failures++; $display("FAIL mid_reset_status got=%b %b %0d exp=0 0 0", system_ena, load_error, words_loaded); end
        send_word(32'd1);
        send_word(w1);
        repeat (4 * CPB) @(negedge clk);
        checks++; if (wa_q.size() !== 1) begin failures++; $display("FAIL mid_fresh_writes got=%0d exp=1", wa_q.size()); end
        if (wa_q.size() > 0) begin
            checks++; if (wa_q[0] !== 32'd0 || wd_q[0] !== w1) begin failures++; $display("FAIL mid_fresh_data got=%h@%h exp=%h@0", wd_q[0], wa_q[0], w1); end
        end
        checks++; if (system_ena !== 1'b1) begin failures++; $display("FAIL mid_fresh_ena got=%b exp=1", system_ena); end
        $display("test_reset_mid_load writes=%0d ena=%b", wa_q.size(), system_ena);
    endtask

    task automatic test_random_images();
        for (int it = 0; it < 3; it++) begin
            int unsigned n;
            logic [31:0] img[$];
            n = $urandom_range(1, 5);
            img.delete();
            for (int i = 0; i < int'(n); i++) img.push_back($urandom);
            do_reset();
            send_word(32'(n));
            foreach (img[i]) send_word(img[i]);
            repeat (4 * CPB) @(negedge clk);
            checks++; if (wa_q.size() !== int'(n)) begin failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, wa_q.size(), n); end
            for (int i = 0; i < int'(n) && i < wa_q.size(); i++) begin
                checks++; if (wa_q[i] !== 32'(4 * i) || wd_q[i] !== img[i])
                    begin failures++; $display("FAIL rnd%0d_w%0d got=%h@%h exp=%h@%h", it, i, wd_q[i], wa_q[i], img[i], 4 * i); end
            end
            checks++; if (words_loaded !== 16'(n) || system_ena !== 1'b1)
                begin failures++; $display("FAIL rnd%0d_status got=%0d/%b exp=%0d/1", it, words_loaded, system_ena, n); end
            $display("test_random_images iter=%0d n=%0d writes=%0d", it, n, wa_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_header();
        test_oversize();
        test_framing();
        test_glitch();
        test_reset_mid_load();
        test_random_images();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
